// File: rtl/ws2811_frame_buffer_if.sv
// Host/driver bus of the ws2811 frame buffer: pixel writes, swap control,
// brightness and the per-pixel read port used by the strip driver.
interface ws2811_frame_buffer_if #(
    parameter int ADDR_W = 2
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic              swap_req;
    logic [7:0]        brightness;
    logic              swap_pending;
    logic              frame_start;
    logic              data_request;
    logic [ADDR_W-1:0] led_addr;
    logic [7:0]        red_out;
    logic [7:0]        green_out;
    logic [7:0]        blue_out;

    modport master (
        output wr_en, wr_addr, wr_data, swap_req, brightness, data_request, led_addr,
        input  swap_pending, frame_start, red_out, green_out, blue_out
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, swap_req, brightness, data_request, led_addr,
        output swap_pending, frame_start, red_out, green_out, blue_out
    );
endinterface

// File: rtl/ws2811_frame_buffer.sv
// Double-buffered GRB frame store: host writes the back bank, the driver reads
// the front bank; banks swap and brightness reloads only when pixel 0 is requested.
module ws2811_frame_buffer #(
    parameter int NUM_LEDS = 4,
    parameter int ADDR_W   = (NUM_LEDS > 2) ? $clog2(NUM_LEDS) : 1
) (
    input  logic clk,
    input  logic reset,
    ws2811_frame_buffer_if.slave bus
);
    localparam logic [ADDR_W:0] LED_LIMIT = NUM_LEDS[ADDR_W:0];

    logic        front_sel_reg, front_sel_next;
    logic        swap_pending_reg, swap_pending_next;
    logic [7:0]  bright_reg;
    logic        frame_start_reg;
    logic        pix_valid_reg;
    logic        pix_bank_reg;
    logic        frame_hit;
    logic        wr_ok;
    logic        rd_ok;
    logic [23:0] pix;
    logic [23:0] scaled;
    logic [15:0] scale_factor;

    always_comb begin
        frame_hit         = bus.data_request && (bus.led_addr == '0);
        wr_ok             = bus.wr_en && ({1'b0, bus.wr_addr} < LED_LIMIT);
        rd_ok             = bus.data_request && ({1'b0, bus.led_addr} < LED_LIMIT);
        // The frame-0 read already sees the bank it swaps to.
        front_sel_next    = front_sel_reg ^ (frame_hit && swap_pending_reg);
        // A request arriving with the frame start survives for the next frame.
        swap_pending_next = (swap_pending_reg && !frame_hit) || bus.swap_req;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            front_sel_reg    <= 1'b0;
            swap_pending_reg <= 1'b0;
            bright_reg       <= 8'hFF;
            frame_start_reg  <= 1'b0;
            pix_valid_reg    <= 1'b0;
            pix_bank_reg     <= 1'b0;
        end else begin
            front_sel_reg    <= front_sel_next;
            swap_pending_reg <= swap_pending_next;
            frame_start_reg  <= frame_hit;
            if (frame_hit) begin
                bright_reg <= bus.brightness;
            end
            if (bus.data_request) begin
                pix_valid_reg <= rd_ok;
                pix_bank_reg  <= front_sel_next;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            localparam logic BANK_ID = 1'(gi);
            logic [23:0] mem [NUM_LEDS];
            logic [23:0] rd_q;

            // Registered read port; only the bank serving the request is enabled.
            always_ff @(posedge clk) begin
                if (wr_ok && (front_sel_reg != BANK_ID)) begin
                    mem[bus.wr_addr] <= bus.wr_data;
                end
                if (rd_ok && (front_sel_next == BANK_ID)) begin
                    rd_q <= mem[bus.led_addr];
                end
            end
        end
    endgenerate

    assign pix          = !pix_valid_reg ? 24'd0
                        : (pix_bank_reg ? g_bank[1].rd_q : g_bank[0].rd_q);
    assign scale_factor = {8'd0, bright_reg} + 16'd1;

    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [15:0] product;
            assign product              = {8'd0, pix[8*gi +: 8]} * scale_factor;
            assign scaled[8*gi +: 8]    = 8'(product >> 8);
        end
    endgenerate

    assign bus.green_out    = scaled[23:16];
    assign bus.red_out      = scaled[15:8];
    assign bus.blue_out     = scaled[7:0];
    assign bus.frame_start  = frame_start_reg;
    assign bus.swap_pending = swap_pending_reg;
endmodule

// File: tb/tb_ws2811_frame_buffer.sv
// Bench for ws2811_frame_buffer (NUM_LEDS=5): constant vector table, hand-written
// corner sequences and random traffic, all checked against a bank/pixel model.
module tb_ws2811_frame_buffer;
    localparam int N  = 5;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ws2811_frame_buffer_if #(.ADDR_W(AW)) bus ();
    ws2811_frame_buffer #(.NUM_LEDS(N), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [2:0]  wa;
        logic [23:0] wd;
        logic        sw;
        logic [7:0]  br;
        logic        dr;
        logic [2:0]  la;
        logic        chk;
        logic [23:0] egrb;
        logic        efs;
        logic        epend;
    } vec_t;

    // Reference model state
    logic [23:0] mem_m   [2][N];
    bit          known_m [2][N];
    int          front_m, pend_m, bright_m;
    logic [23:0] pix_m;
    bit          pix_known;
    bit          fs_m;

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    function automatic int scale(input int c, input int b);
        return (c * (b + 1)) / 256;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (txn %0d)", name, act, exp, txn);
        end
    endtask

    function automatic vec_t row(input logic rst, input logic we, input logic [2:0] wa,
                                 input logic [23:0] wd, input logic sw, input logic [7:0] br,
                                 input logic dr, input logic [2:0] la, input logic chk,
                                 input logic [23:0] egrb, input logic efs, input logic epend);
        vec_t v;
        v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.sw = sw; v.br = br;
        v.dr = dr; v.la = la; v.chk = chk; v.egrb = egrb; v.efs = efs; v.epend = epend;
        return v;
    endfunction

    function automatic vec_t idle(input logic [7:0] br);
        return row(0, 0, 0, 0, 0, br, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic run(input vec_t v, input string tag);
        bit fs;
        int nf;
        reset            = v.rst;
        bus.wr_en        = v.we;
        bus.wr_addr      = v.wa;
        bus.wr_data      = v.wd;
        bus.swap_req     = v.sw;
        bus.brightness   = v.br;
        bus.data_request = v.dr;
        bus.led_addr     = v.la;
        if (v.rst) begin
            front_m = 0; pend_m = 0; bright_m = 255;
            pix_m = 0; pix_known = 1; fs_m = 0;
        end else begin
            fs = v.dr && (v.la == 0);
            nf = (fs && pend_m != 0) ? 1 - front_m : front_m;
            if (v.dr) begin
                if (v.la < N) begin
                    pix_m     = mem_m[nf][v.la];
                    pix_known = known_m[nf][v.la];
                end else begin
                    pix_m     = 0;
                    pix_known = 1;
                end
            end
            if (v.we && v.wa < N) begin
                mem_m[1-front_m][v.wa]   = v.wd;
                known_m[1-front_m][v.wa] = 1;
            end
            if (fs) bright_m = v.br;
            pend_m  = ((pend_m != 0) && !fs) || v.sw;
            front_m = nf;
            fs_m    = fs;
        end
        @(posedge clk);
        #1;
        txn++;
        check("frame_start", bus.frame_start, fs_m);
        check("swap_pending", bus.swap_pending, pend_m);
        if (pix_known) begin
            check("green", bus.green_out, scale(pix_m[23:16], bright_m));
            check("red",   bus.red_out,   scale(pix_m[15:8],  bright_m));
            check("blue",  bus.blue_out,  scale(pix_m[7:0],   bright_m));
        end
        if (v.chk) begin
            check("tbl_grb", {bus.green_out, bus.red_out, bus.blue_out}, v.egrb);
            check("tbl_fs", bus.frame_start, v.efs);
            check("tbl_pend", bus.swap_pending, v.epend);
        end
        $display("txn %0d %s rst=%0d we=%0d wa=%0d dr=%0d la=%0d sw=%0d -> grb=%02h%02h%02h fs=%0d pend=%0d",
                 txn, tag, v.rst, v.we, v.wa, v.dr, v.la, v.sw,
                 bus.green_out, bus.red_out, bus.blue_out, bus.frame_start, bus.swap_pending);
    endtask

    vec_t        tbl [$];
    vec_t        v;
    logic [23:0] new_px [3];
    logic [23:0] old_px [3];

    initial begin
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < N; a++) begin
                mem_m[b][a] = 0; known_m[b][a] = 0;
            end
        front_m = 0; pend_m = 0; bright_m = 255; pix_m = 0; pix_known = 1; fs_m = 0;
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.swap_req = 0;
        bus.brightness = 8'hFF; bus.data_request = 0; bus.led_addr = 0;

        // Reset, fill bank 1, swap, read frame; then brightness 127 and a mid-frame change
        tbl.push_back(row(1, 0, 0, 24'h000000, 0, 8'hFF, 0, 0, 1, 24'h000000, 0, 0));
        tbl.push_back(row(0, 1, 0, 24'h0A0B0C, 0, 8'hFF, 0, 0, 1, 24'h000000, 0, 0));
        tbl.push_back(row(0, 1, 1, 24'h112233, 0, 8'hFF, 0, 0, 1, 24'h000000, 0, 0));
        tbl.push_back(row(0, 1, 2, 24'h445566, 0, 8'hFF, 0, 0, 1, 24'h000000, 0, 0));
        tbl.push_back(row(0, 1, 3, 24'hFFFFFF, 0, 8'hFF, 0, 0, 1, 24'h000000, 0, 0));
        tbl.push_back(row(0, 0, 0, 24'h000000, 1, 8'hFF, 0, 0, 1, 24'h000000, 0, 1));
        tbl.push_back(row(0, 0, 0, 24'h000000, 0, 8'hFF, 1, 0, 1, 24'h0A0B0C, 1, 0));
        tbl.push_back(row(0, 0, 0, 24'h000000, 0, 8'hFF, 1, 1, 1, 24'h112233, 0, 0));
        tbl.push_back(row(0, 0, 0, 24'h000000, 0, 8'hFF, 1, 2, 1, 24'h445566, 0, 0));
        tbl.push_back(row(0, 0, 0, 24'h000000, 0, 8'hFF, 1, 3, 1, 24'hFFFFFF, 0, 0));
        tbl.push_back(row(0, 0, 0, 24'h000000, 0, 8'hFF, 0, 0, 1, 24'hFFFFFF, 0, 0));
        tbl.push_back(row(0, 1, 0, 24'hC86432, 0, 8'd127, 0, 0, 1, 24'hFFFFFF, 0, 0));
        tbl.push_back(row(0, 1, 1, 24'h808080, 0, 8'd127, 0, 0, 1, 24'hFFFFFF, 0, 0));
        tbl.push_back(row(0, 0, 0, 24'h000000, 1, 8'd127, 0, 0, 1, 24'hFFFFFF, 0, 1));
        tbl.push_back(row(0, 0, 0, 24'h000000, 0, 8'd127, 1, 0, 1, 24'h643219, 1, 0));
        tbl.push_back(row(0, 0, 0, 24'h000000, 0, 8'd0,   1, 1, 1, 24'h404040, 0, 0));
        tbl.push_back(row(0, 0, 0, 24'h000000, 0, 8'd0,   1, 0, 1, 24'h000000, 1, 0));
        foreach (tbl[i]) run(tbl[i], "table");

        // Swap request coincident with a frame start: this frame old bank, next frame new
        run(row(0, 0, 0, 0, 1, 8'hFF, 1, 0, 0, 0, 0, 0), "swap_coincident");
        check("coinc_old_green", bus.green_out, 8'hC8);
        check("coinc_pending", bus.swap_pending, 1);
        run(row(0, 0, 0, 0, 0, 8'hFF, 1, 1, 0, 0, 0, 0), "swap_coincident");
        run(row(0, 0, 0, 0, 0, 8'hFF, 1, 0, 0, 0, 0, 0), "swap_coincident");
        check("coinc_new_green", bus.green_out, 8'h0A);
        check("coinc_cleared", bus.swap_pending, 0);

        // Out-of-range write is ignored, out-of-range reads return 0
        run(row(0, 1, 5, 24'h123456, 0, 8'hFF, 0, 0, 0, 0, 0, 0), "oob_write");
        run(row(0, 0, 0, 0, 0, 8'hFF, 1, 6, 0, 0, 0, 0), "oob_read");
        check("oob_grb6", {bus.green_out, bus.red_out, bus.blue_out}, 0);
        run(row(0, 0, 0, 0, 0, 8'hFF, 1, 1, 0, 0, 0, 0), "read");
        run(row(0, 0, 0, 0, 0, 8'hFF, 1, 5, 0, 0, 0, 0), "oob_read");
        check("oob_grb5", {bus.green_out, bus.red_out, bus.blue_out}, 0);

        // Back-bank writes while the front bank is read
        old_px[0] = 24'h112233; old_px[1] = 24'h445566; old_px[2] = 24'hFFFFFF;
        for (int a = 0; a < 3; a++) begin
            new_px[a] = 24'($urandom);
            run(row(0, 1, 3'(a + 2), new_px[a], 0, 8'hFF, 1, 3'(a + 1), 0, 0, 0, 0), "write_during_read");
            check("front_stable", {bus.green_out, bus.red_out, bus.blue_out}, old_px[a]);
        end
        run(row(0, 0, 0, 0, 1, 8'hFF, 0, 0, 0, 0, 0, 0), "swap_req");
        run(row(0, 0, 0, 0, 0, 8'hFF, 1, 0, 0, 0, 0, 0), "frame0");
        run(row(0, 0, 0, 0, 0, 8'hFF, 1, 2, 0, 0, 0, 0), "read_new");
        check("swapped_px", {bus.green_out, bus.red_out, bus.blue_out}, new_px[0]);

        // Reset in the middle of a frame with a swap pending and low brightness
        run(row(0, 0, 0, 0, 1, 8'hFF, 0, 0, 0, 0, 0, 0), "swap_req");
        run(row(0, 0, 0, 0, 0, 8'h10, 1, 0, 0, 0, 0, 0), "frame0");
        run(row(0, 0, 0, 0, 1, 8'h10, 1, 1, 0, 0, 0, 0), "read");
        run(row(1, 0, 0, 0, 0, 8'h10, 1, 2, 0, 0, 0, 0), "reset_mid");
        check("rst_grb", {bus.green_out, bus.red_out, bus.blue_out}, 0);
        check("rst_pending", bus.swap_pending, 0);
        run(row(0, 0, 0, 0, 0, 8'hFF, 1, 1, 0, 0, 0, 0), "after_reset");
        check("rst_bank0_full", {bus.green_out, bus.red_out, bus.blue_out}, 24'h808080);
        run(row(0, 0, 0, 0, 0, 8'hFF, 1, 0, 0, 0, 0, 0), "after_reset");
        check("rst_frame_bank0", {bus.green_out, bus.red_out, bus.blue_out}, 24'hC86432);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            v     = idle(8'($urandom));
            v.we  = ($urandom_range(0, 1) == 1);
            v.wa  = 3'($urandom_range(0, 7));
            v.wd  = 24'($urandom);
            v.sw  = ($urandom_range(0, 7) == 0);
            v.dr  = ($urandom_range(0, 9) < 6);
            v.la  = ($urandom_range(0, 5) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
            run(v, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
